// File: rtl/riscv_core_ctrl_pkg.sv
// Shared types and constants for the core controller: FSM states and the
// multi-bit encodings used for the fetch enable.
package riscv_core_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_HOLD    = 3'd0,
        ST_RELEASE = 3'd1,
        ST_RUN     = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_HALTED  = 3'd4
    } ctrl_state_e;

    localparam logic [3:0] MUBI4_ON  = 4'b0101;
    localparam logic [3:0] MUBI4_OFF = 4'b1010;

endpackage

// File: rtl/riscv_bus_watchdog.sv
// Per-bus watchdog: tracks outstanding transactions (saturating 2-bit count)
// and flags a timeout when a response has been missing for BUS_TIMEOUT cycles.
// o_timeout is a single-cycle strobe that coincides with the edge on which
// the count and timer are cleared.
module riscv_bus_watchdog #(
    parameter int BUS_TIMEOUT = 256
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    input  logic       i_req,
    input  logic       i_gnt,
    input  logic       i_rvalid,
    output logic       o_timeout,
    output logic [1:0] o_outstanding
);

    localparam int TW = $clog2(BUS_TIMEOUT + 1);

    logic [1:0]    r_cnt;
    logic [TW-1:0] r_timer;
    logic          w_inc;

    assign w_inc         = i_req & i_gnt;
    assign o_outstanding = r_cnt;

    // The timer is one short of the limit and another silent cycle is passing.
    assign o_timeout = i_en && (r_cnt != 2'd0) && !i_rvalid &&
                       (r_timer == TW'(BUS_TIMEOUT - 1));

    // Outstanding count and response timer; both forced to zero while the core is in reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= 2'd0;
            r_timer <= '0;
        end else if (!i_en || o_timeout) begin
            r_cnt   <= 2'd0;
            r_timer <= '0;
        end else begin
            case ({w_inc, i_rvalid})
                2'b10:   if (r_cnt != 2'd3) r_cnt <= r_cnt + 2'd1;
                2'b01:   if (r_cnt != 2'd0) r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
            if (r_cnt == 2'd0 || i_rvalid) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + TW'(1);
            end
        end
    end

endmodule

// File: rtl/riscv_core_ctrl.sv
// Core controller: boot reset sequencing, fetch gating with halt/drain,
// interrupt synchronisation and instruction/data bus watchdogs.
module riscv_core_ctrl
    import riscv_core_ctrl_pkg::*;
#(
    parameter int NUM_IRQ     = 15,
    parameter int SYNC_STAGES = 2,
    parameter int BOOT_DELAY  = 16,
    parameter int BUS_TIMEOUT = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               halt_req_i,
    input  logic               resume_i,
    input  logic [NUM_IRQ-1:0] irq_fast_i,
    input  logic [2:0]         irq_std_i,
    input  logic               instr_req_i,
    input  logic               instr_gnt_i,
    input  logic               instr_rvalid_i,
    input  logic               data_req_i,
    input  logic               data_gnt_i,
    input  logic               data_rvalid_i,
    input  logic               timeout_clr_i,
    output logic               core_rst_no,
    output logic [3:0]         fetch_enable_o,
    output logic [14:0]        irq_fast_o,
    output logic [2:0]         irq_std_o,
    output logic               irq_nm_o,
    output logic               halted_o,
    output logic [1:0]         bus_timeout_o
);

    localparam int BW = $clog2(BOOT_DELAY + 1);

    ctrl_state_e                   r_state;
    logic [BW-1:0]                 r_boot_cnt;
    logic                          r_core_rst_n;
    logic [3:0]                    r_fetch;
    logic                          r_halted;
    logic                          r_irq_nm;
    logic [1:0]                    r_bus_to;
    logic [SYNC_STAGES-1:0][17:0]  r_sync;

    logic [14:0] w_irq_fast_ext;
    logic [1:0]  w_to;
    logic [1:0]  w_cnt_instr;
    logic [1:0]  w_cnt_data;

    assign core_rst_no    = r_core_rst_n;
    assign fetch_enable_o = r_fetch;
    assign halted_o       = r_halted;
    assign irq_nm_o       = r_irq_nm;
    assign bus_timeout_o  = r_bus_to;
    assign irq_fast_o     = r_sync[SYNC_STAGES-1][14:0];
    assign irq_std_o      = r_sync[SYNC_STAGES-1][17:15];

    // Zero-extend the used fast IRQ lines to the full 15-bit field.
    always_comb begin
        w_irq_fast_ext               = '0;
        w_irq_fast_ext[NUM_IRQ-1:0]  = irq_fast_i;
    end

    // Synchroniser chain shared by the fast and standard interrupt lines.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], {irq_std_i, w_irq_fast_ext}};
        end
    end

    riscv_bus_watchdog #(.BUS_TIMEOUT(BUS_TIMEOUT)) u_wd_instr (
        .i_clk         (clk),
        .i_rst_n       (rst),
        .i_en          (r_core_rst_n),
        .i_req         (instr_req_i),
        .i_gnt         (instr_gnt_i),
        .i_rvalid      (instr_rvalid_i),
        .o_timeout     (w_to[0]),
        .o_outstanding (w_cnt_instr)
    );

    riscv_bus_watchdog #(.BUS_TIMEOUT(BUS_TIMEOUT)) u_wd_data (
        .i_clk         (clk),
        .i_rst_n       (rst),
        .i_en          (r_core_rst_n),
        .i_req         (data_req_i),
        .i_gnt         (data_gnt_i),
        .i_rvalid      (data_rvalid_i),
        .o_timeout     (w_to[1]),
        .o_outstanding (w_cnt_data)
    );

    // Sticky timeout flags (a new timeout beats a clear) and the NMI strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bus_to <= 2'b00;
            r_irq_nm <= 1'b0;
        end else begin
            r_bus_to <= w_to | (r_bus_to & {2{~timeout_clr_i}});
            r_irq_nm <= |w_to;
        end
    end

    // Control FSM; outputs are registered alongside each state change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_HOLD;
            r_boot_cnt   <= '0;
            r_core_rst_n <= 1'b0;
            r_fetch      <= MUBI4_OFF;
            r_halted     <= 1'b0;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (r_boot_cnt == BW'(BOOT_DELAY - 1)) begin
                        r_state      <= ST_RELEASE;
                        r_core_rst_n <= 1'b1;
                    end else begin
                        r_boot_cnt <= r_boot_cnt + BW'(1);
                    end
                end
                ST_RELEASE: begin
                    r_state <= ST_RUN;
                    r_fetch <= MUBI4_ON;
                end
                ST_RUN: begin
                    if (halt_req_i) begin
                        r_state <= ST_DRAIN;
                        r_fetch <= MUBI4_OFF;
                    end
                end
                ST_DRAIN: begin
                    if ((|w_to) || (w_cnt_instr == 2'd0 && w_cnt_data == 2'd0)) begin
                        r_state  <= ST_HALTED;
                        r_halted <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    if (resume_i) begin
                        r_state  <= ST_RUN;
                        r_fetch  <= MUBI4_ON;
                        r_halted <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ST_HOLD;
                    r_boot_cnt   <= '0;
                    r_core_rst_n <= 1'b0;
                    r_fetch      <= MUBI4_OFF;
                    r_halted     <= 1'b0;
                end
            endcase
        end
    end

endmodule
